// File: rtl/dmac_top.sv
// 4-channel memory-to-memory DMA: APB configuration slave, AXI3 master, one shared round-robin burst engine.
// Define DMAC_SLVERR_EN to flag unmapped or read-only APB accesses on pslverr_o.
module dmac_top #(
  parameter int          N_CH       = 4,
  parameter int          BUF_DEPTH  = 16,
  parameter logic [31:0] IP_VERSION = 32'h0001_2024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [11:0] paddr_i,
  input  logic [31:0] pwdata_i,
  output logic [31:0] prdata_o,
  output logic        pready_o,
  output logic        pslverr_o,
  output logic [3:0]  awid_o,
  output logic [31:0] awaddr_o,
  output logic [3:0]  awlen_o,
  output logic [2:0]  awsize_o,
  output logic [1:0]  awburst_o,
  output logic        awvalid_o,
  input  logic        awready_i,
  output logic [3:0]  wid_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        wlast_o,
  output logic        wvalid_o,
  input  logic        wready_i,
  input  logic [3:0]  bid_i,
  input  logic [1:0]  bresp_i,
  input  logic        bvalid_i,
  output logic        bready_o,
  output logic [3:0]  arid_o,
  output logic [31:0] araddr_o,
  output logic [3:0]  arlen_o,
  output logic [2:0]  arsize_o,
  output logic [1:0]  arburst_o,
  output logic        arvalid_o,
  input  logic        arready_i,
  input  logic [3:0]  rid_i,
  input  logic [1:0]  rresp_i,
  input  logic [31:0] rdata_i,
  input  logic        rlast_i,
  input  logic        rvalid_i,
  output logic        rready_o
);

  localparam int CW = $clog2(N_CH);
  localparam int BW = $clog2(BUF_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ARB, ST_RADDR, ST_RDATA, ST_WADDR, ST_WDATA, ST_WRESP
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     src_q [N_CH];
  logic [31:0]     src_d [N_CH];
  logic [31:0]     dst_q [N_CH];
  logic [31:0]     dst_d [N_CH];
  logic [15:0]     len_q [N_CH];
  logic [15:0]     len_d [N_CH];
  logic [31:0]     cur_src_q [N_CH];
  logic [31:0]     cur_src_d [N_CH];
  logic [31:0]     cur_dst_q [N_CH];
  logic [31:0]     cur_dst_d [N_CH];
  logic [15:0]     rem_q [N_CH];
  logic [15:0]     rem_d [N_CH];
  logic [N_CH-1:0] busy_q, busy_d;
  logic [31:0]     buf_q [BUF_DEPTH];
  logic [31:0]     buf_d [BUF_DEPTH];
  logic [CW-1:0]   gnt_q, gnt_d;
  logic [CW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]   cnt_q, cnt_d;

  logic          apb_acc, apb_wr;
  logic [3:0]    page;
  logic [7:0]    off;
  logic          ch_hit, is_ver, off_src, off_dst, off_len, off_cmd, off_stat, mapped;
  logic [CW-1:0] ch_idx;
  logic [15:0]   rem_g, bytes_g;
  logic [3:0]    axlen;
  logic          sel_found;
  logic [CW-1:0] sel_ch, cand;
  logic          unused;

  assign unused = ^{bid_i, bresp_i, rid_i, rresp_i};

  assign apb_acc  = psel_i & penable_i;
  assign apb_wr   = apb_acc & pwrite_i;
  assign page     = paddr_i[11:8];
  assign off      = paddr_i[7:0];
  assign ch_hit   = (page != 4'd0) && (page <= 4'(N_CH));
  assign ch_idx   = CW'(page - 4'd1);
  assign is_ver   = (paddr_i == 12'h000);
  assign off_src  = (off == 8'h00);
  assign off_dst  = (off == 8'h04);
  assign off_len  = (off == 8'h08);
  assign off_cmd  = (off == 8'h0C);
  assign off_stat = (off == 8'h10);
  assign mapped   = is_ver | (ch_hit & (off_src | off_dst | off_len | off_cmd | off_stat));

  assign pready_o = 1'b1;
`ifdef DMAC_SLVERR_EN
  assign pslverr_o = apb_acc & (~mapped | (pwrite_i & (is_ver | (ch_hit & off_stat))));
`else
  assign pslverr_o = 1'b0;
`endif

  always_comb begin
    prdata_o = '0;
    if (apb_acc && !pwrite_i) begin
      if (is_ver) begin
        prdata_o = IP_VERSION;
      end else if (ch_hit) begin
        if (off_src)  prdata_o = src_q[ch_idx];
        if (off_dst)  prdata_o = dst_q[ch_idx];
        if (off_len)  prdata_o = {16'd0, len_q[ch_idx]};
        if (off_stat) prdata_o = {31'd0, ~busy_q[ch_idx]};
      end
    end
  end

  // Burst size of the granted channel; axlen wraps 0-1 to 15 for a full 64-byte burst.
  assign rem_g   = rem_q[gnt_q];
  assign bytes_g = (rem_g >= 16'd64) ? 16'd64 : rem_g;
  assign axlen   = bytes_g[5:2] - 4'd1;

  always_comb begin
    sel_found = 1'b0;
    sel_ch    = '0;
    cand      = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      cand = rr_ptr_q + CW'(i);
      if (!sel_found && busy_q[cand]) begin
        sel_found = 1'b1;
        sel_ch    = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    cur_src_d = cur_src_q;
    cur_dst_d = cur_dst_q;
    rem_d     = rem_q;
    busy_d    = busy_q;
    buf_d     = buf_q;
    gnt_d     = gnt_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;

    awid_o    = '0;
    awaddr_o  = '0;
    awlen_o   = '0;
    awsize_o  = 3'd2;
    awburst_o = 2'b01;
    awvalid_o = 1'b0;
    wid_o     = '0;
    wdata_o   = '0;
    wstrb_o   = 4'hF;
    wlast_o   = 1'b0;
    wvalid_o  = 1'b0;
    bready_o  = 1'b0;
    arid_o    = '0;
    araddr_o  = '0;
    arlen_o   = '0;
    arsize_o  = 3'd2;
    arburst_o = 2'b01;
    arvalid_o = 1'b0;
    rready_o  = 1'b0;

    if (apb_wr && ch_hit) begin
      if (off_src) src_d[ch_idx] = pwdata_i;
      if (off_dst) dst_d[ch_idx] = pwdata_i;
      if (off_len) len_d[ch_idx] = pwdata_i[15:0];
      if (off_cmd && pwdata_i[0] && !busy_q[ch_idx]) begin
        cur_src_d[ch_idx] = src_q[ch_idx];
        cur_dst_d[ch_idx] = dst_q[ch_idx];
        rem_d[ch_idx]     = len_q[ch_idx] & ~16'd3;
        busy_d[ch_idx]    = ((len_q[ch_idx] & ~16'd3) != 16'd0);
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (|busy_q) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (sel_found) begin
          gnt_d    = sel_ch;
          rr_ptr_d = sel_ch + CW'(1);
          cnt_d    = '0;
          state_d  = ST_RADDR;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RADDR: begin
        arvalid_o = 1'b1;
        araddr_o  = cur_src_q[gnt_q];
        arlen_o   = axlen;
        if (arready_i) begin
          cnt_d   = '0;
          state_d = ST_RDATA;
        end
      end
      ST_RDATA: begin
        rready_o = 1'b1;
        if (rvalid_i) begin
          buf_d[cnt_q] = rdata_i;
          cnt_d        = cnt_q + BW'(1);
          if (rlast_i) begin
            cnt_d   = '0;
            state_d = ST_WADDR;
          end
        end
      end
      ST_WADDR: begin
        awvalid_o = 1'b1;
        awaddr_o  = cur_dst_q[gnt_q];
        awlen_o   = axlen;
        if (awready_i) begin
          cnt_d   = '0;
          state_d = ST_WDATA;
        end
      end
      ST_WDATA: begin
        wvalid_o = 1'b1;
        wdata_o  = buf_q[cnt_q];
        wlast_o  = (cnt_q == axlen);
        if (wready_i) begin
          cnt_d = cnt_q + BW'(1);
          if (wlast_o) state_d = ST_WRESP;
        end
      end
      ST_WRESP: begin
        bready_o = 1'b1;
        if (bvalid_i) begin
          cur_src_d[gnt_q] = cur_src_q[gnt_q] + {16'd0, bytes_g};
          cur_dst_d[gnt_q] = cur_dst_q[gnt_q] + {16'd0, bytes_g};
          rem_d[gnt_q]     = rem_g - bytes_g;
          if (rem_g == bytes_g) busy_d[gnt_q] = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      src_q     <= '{default: '0};
      dst_q     <= '{default: '0};
      len_q     <= '{default: '0};
      cur_src_q <= '{default: '0};
      cur_dst_q <= '{default: '0};
      rem_q     <= '{default: '0};
      busy_q    <= '0;
      buf_q     <= '{default: '0};
      gnt_q     <= '0;
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      cur_src_q <= cur_src_d;
      cur_dst_q <= cur_dst_d;
      rem_q     <= rem_d;
      busy_q    <= busy_d;
      buf_q     <= buf_d;
      gnt_q     <= gnt_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dmac_top.sv
// Directed bench for dmac_top: APB register map, burst splitting, round-robin order, stalls, async reset.
module tb_dmac_top;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel_i, penable_i, pwrite_i;
  logic [11:0] paddr_i;
  logic [31:0] pwdata_i, prdata_o;
  logic        pready_o, pslverr_o;
  logic [3:0]  awid_o, awlen_o, wid_o, wstrb_o, bid_i, arid_o, arlen_o, rid_i;
  logic [31:0] awaddr_o, wdata_o, araddr_o, rdata_i;
  logic [2:0]  awsize_o, arsize_o;
  logic [1:0]  awburst_o, arburst_o, bresp_i, rresp_i;
  logic        awvalid_o, awready_i, wlast_o, wvalid_o, wready_i, bvalid_i, bready_o;
  logic        arvalid_o, arready_i, rlast_i, rvalid_i, rready_o;

  always #5 clk = ~clk;

  dmac_top dut (
    .clk(clk), .rst(rst),
    .psel_i(psel_i), .penable_i(penable_i), .pwrite_i(pwrite_i), .paddr_i(paddr_i),
    .pwdata_i(pwdata_i), .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
    .awid_o(awid_o), .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o),
    .awburst_o(awburst_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wid_o(wid_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o),
    .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
    .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o),
    .arburst_o(arburst_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rid_i(rid_i), .rresp_i(rresp_i), .rdata_i(rdata_i), .rlast_i(rlast_i),
    .rvalid_i(rvalid_i), .rready_o(rready_o)
  );

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;
  logic [31:0] mem [logic [31:0]];
  bit          stall_en = 1'b0;
  logic [35:0] ar_log [$];
  logic [35:0] aw_log [$];
  int unsigned rbeats, wbeats, wlast_cnt;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[15:0]};
  endfunction

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : pat(a);
  endfunction

  // AXI slave memory model plus handshake-stability monitor
  initial begin : slave
    logic        hs_ar, hs_r, hs_aw, hs_w, hs_b;
    logic [31:0] ar_a, aw_a, w_d, p_araddr, p_awaddr, p_wdata;
    logic [3:0]  ar_l, aw_l, p_arlen, p_awlen;
    logic        w_l, p_ar, p_aw, p_w, p_wlast, b_pend;
    int          r_left, w_left;
    logic [31:0] r_addr, w_addr;
    arready_i = 0; rvalid_i = 0; rlast_i = 0; rdata_i = '0; rid_i = '0; rresp_i = '0;
    awready_i = 0; wready_i = 0; bvalid_i = 0; bid_i = '0; bresp_i = '0;
    p_ar = 0; p_aw = 0; p_w = 0; b_pend = 0; r_left = 0; w_left = 0;
    r_addr = '0; w_addr = '0; p_araddr = '0; p_awaddr = '0; p_wdata = '0;
    p_arlen = '0; p_awlen = '0; p_wlast = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        arready_i = 0; rvalid_i = 0; rlast_i = 0; awready_i = 0; wready_i = 0; bvalid_i = 0;
        p_ar = 0; p_aw = 0; p_w = 0; b_pend = 0; r_left = 0; w_left = 0;
        continue;
      end
      hs_ar = arvalid_o & arready_i; ar_a = araddr_o; ar_l = arlen_o;
      hs_r  = rvalid_i & rready_o;
      hs_aw = awvalid_o & awready_i; aw_a = awaddr_o; aw_l = awlen_o;
      hs_w  = wvalid_o & wready_i; w_d = wdata_o; w_l = wlast_o;
      hs_b  = bvalid_i & bready_o;
      if (p_ar) begin
        n_chk++;
        if (arvalid_o !== 1'b1 || araddr_o !== p_araddr || arlen_o !== p_arlen) begin
          n_bad++;
          $display("FAIL ar_stable: got v=%b a=%h l=%0d want v=1 a=%h l=%0d",
                   arvalid_o, araddr_o, arlen_o, p_araddr, p_arlen);
        end
      end
      if (p_aw) begin
        n_chk++;
        if (awvalid_o !== 1'b1 || awaddr_o !== p_awaddr || awlen_o !== p_awlen) begin
          n_bad++;
          $display("FAIL aw_stable: got v=%b a=%h l=%0d want v=1 a=%h l=%0d",
                   awvalid_o, awaddr_o, awlen_o, p_awaddr, p_awlen);
        end
      end
      if (p_w) begin
        n_chk++;
        if (wvalid_o !== 1'b1 || wdata_o !== p_wdata || wlast_o !== p_wlast) begin
          n_bad++;
          $display("FAIL w_stable: got v=%b d=%h last=%b want v=1 d=%h last=%b",
                   wvalid_o, wdata_o, wlast_o, p_wdata, p_wlast);
        end
      end
      if (hs_w) begin
        n_chk++;
        if (w_left == 0 || w_l !== (w_left == 1)) begin
          n_bad++;
          $display("FAIL wlast: got %b with %0d beats left, want %b", w_l, w_left, (w_left == 1));
        end
      end
      p_ar = arvalid_o & ~arready_i; p_araddr = araddr_o; p_arlen = arlen_o;
      p_aw = awvalid_o & ~awready_i; p_awaddr = awaddr_o; p_awlen = awlen_o;
      p_w  = wvalid_o & ~wready_i;   p_wdata  = wdata_o;  p_wlast = wlast_o;
      #1;
      if (hs_ar) begin
        r_addr = ar_a; r_left = int'(ar_l) + 1; ar_log.push_back({ar_l, ar_a});
      end
      if (hs_r) begin
        rbeats++; r_addr += 32'd4; r_left--; rvalid_i = 0; rlast_i = 0;
      end
      if (r_left != 0 && !rvalid_i && (!stall_en || $urandom_range(2, 0) != 0)) begin
        rvalid_i = 1; rdata_i = rd(r_addr); rlast_i = (r_left == 1);
      end
      if (hs_aw) begin
        w_addr = aw_a; w_left = int'(aw_l) + 1; aw_log.push_back({aw_l, aw_a});
      end
      if (hs_w) begin
        mem[w_addr] = w_d; w_addr += 32'd4; wbeats++;
        if (w_l) wlast_cnt++;
        if (w_left != 0) begin
          w_left--;
          if (w_left == 0) b_pend = 1;
        end
      end
      if (hs_b) bvalid_i = 0;
      if (b_pend && !bvalid_i && (!stall_en || $urandom_range(1, 0) != 0)) begin
        bvalid_i = 1; b_pend = 0;
      end
      arready_i = stall_en ? 1'($urandom_range(1, 0)) : 1'b1;
      awready_i = stall_en ? 1'($urandom_range(1, 0)) : 1'b1;
      wready_i  = stall_en ? 1'($urandom_range(1, 0)) : 1'b1;
    end
  end

  task automatic apb_wr(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    psel_i = 1; penable_i = 0; pwrite_i = 1; paddr_i = a; pwdata_i = d;
    @(negedge clk);
    penable_i = 1;
    @(negedge clk);
    psel_i = 0; penable_i = 0; pwrite_i = 0;
  endtask

  task automatic apb_rd(input logic [11:0] a, output logic [31:0] d, output logic e);
    @(negedge clk);
    psel_i = 1; penable_i = 0; pwrite_i = 0; paddr_i = a;
    @(negedge clk);
    penable_i = 1;
    #1;
    d = prdata_o; e = pslverr_o;
    @(negedge clk);
    psel_i = 0; penable_i = 0;
  endtask

  task automatic wait_idle(input int unsigned ch);
    logic [31:0] d;
    logic        e;
    bit          done;
    done = 0;
    for (int i = 0; i < 600 && !done; i++) begin
      apb_rd(12'((ch + 1) * 256 + 16), d, e);
      if (d == 32'd1) done = 1;
    end
    n_chk++;
    if (!done) begin
      n_bad++;
      $display("FAIL idle_timeout ch%0d: STAT got %h want 1", ch, d);
    end
  endtask

  task automatic clear_logs();
    ar_log.delete(); aw_log.delete(); mem.delete();
    rbeats = 0; wbeats = 0; wlast_cnt = 0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        e;
    rst = 1;
    psel_i = 0; penable_i = 0; pwrite_i = 0; paddr_i = '0; pwdata_i = '0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({arvalid_o, rready_o, awvalid_o, wvalid_o, wlast_o, bready_o} !== 6'b0 ||
        araddr_o !== 32'd0 || awaddr_o !== 32'd0 || arlen_o !== 4'd0 || wdata_o !== 32'd0 ||
        prdata_o !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got valids=%b araddr=%h awaddr=%h prdata=%h want all 0",
               {arvalid_o, rready_o, awvalid_o, wvalid_o, wlast_o, bready_o}, araddr_o, awaddr_o, prdata_o);
    end
    rst = 0;
    apb_rd(12'h000, d, e);
    n_chk++;
    if (d !== 32'h0001_2024) begin n_bad++; $display("FAIL version: got %h want 00012024", d); end
    apb_rd(12'h110, d, e);
    n_chk++;
    if (d !== 32'd1) begin n_bad++; $display("FAIL reset_stat0: got %h want 1", d); end
    apb_rd(12'h410, d, e);
    n_chk++;
    if (d !== 32'd1) begin n_bad++; $display("FAIL reset_stat3: got %h want 1", d); end
    apb_rd(12'h108, d, e);
    n_chk++;
    if (d !== 32'd0 || e !== 1'b0) begin n_bad++; $display("FAIL reset_len0: got %h err=%b want 0 err=0", d, e); end
  endtask

  task automatic test_regs();
    logic [31:0] d;
    logic        e;
    logic        exp_err;
`ifdef DMAC_SLVERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    apb_wr(12'h200, 32'h1234_5678);
    apb_wr(12'h208, 32'hFFFF_ABC4);
    apb_rd(12'h200, d, e);
    n_chk++;
    if (d !== 32'h1234_5678) begin n_bad++; $display("FAIL src_rb: got %h want 12345678", d); end
    apb_rd(12'h208, d, e);
    n_chk++;
    if (d !== 32'h0000_ABC4) begin n_bad++; $display("FAIL len_rb: got %h want 0000abc4", d); end
    apb_rd(12'h20C, d, e);
    n_chk++;
    if (d !== 32'd0) begin n_bad++; $display("FAIL cmd_read: got %h want 0", d); end
    apb_wr(12'h000, 32'hDEAD_BEEF);
    apb_rd(12'h000, d, e);
    n_chk++;
    if (d !== 32'h0001_2024) begin n_bad++; $display("FAIL version_ro: got %h want 00012024", d); end
    apb_wr(12'h500, 32'hDEAD_BEEF);
    apb_rd(12'h500, d, e);
    n_chk++;
    if (d !== 32'd0 || e !== exp_err) begin
      n_bad++; $display("FAIL unmapped_500: got %h err=%b want 0 err=%b", d, e, exp_err);
    end
    apb_rd(12'h114, d, e);
    n_chk++;
    if (d !== 32'd0 || e !== exp_err) begin
      n_bad++; $display("FAIL unmapped_114: got %h err=%b want 0 err=%b", d, e, exp_err);
    end
    apb_wr(12'h208, 32'd0);
    apb_wr(12'h200, 32'd0);
  endtask

  task automatic test_single_ch();
    logic [31:0] d;
    logic        e;
    int unsigned bad_words;
    clear_logs();
    apb_wr(12'h100, 32'h0000_0000);
    apb_wr(12'h104, 32'h0000_2000);
    apb_wr(12'h108, 32'h0000_0100);
    apb_wr(12'h10C, 32'd1);
    apb_rd(12'h110, d, e);
    n_chk++;
    if (d !== 32'd0) begin n_bad++; $display("FAIL single_busy: got %h want 0", d); end
    wait_idle(0);
    n_chk++;
    if (ar_log.size() != 4 || aw_log.size() != 4) begin
      n_bad++; $display("FAIL single_bursts: got ar=%0d aw=%0d want 4 4", ar_log.size(), aw_log.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_chk++;
        if (ar_log[k] !== {4'd15, 32'(k * 64)} || aw_log[k] !== {4'd15, 32'(32'h2000 + k * 64)}) begin
          n_bad++;
          $display("FAIL single_addr%0d: got ar=%h aw=%h want ar=%h aw=%h", k, ar_log[k], aw_log[k],
                   {4'd15, 32'(k * 64)}, {4'd15, 32'(32'h2000 + k * 64)});
        end
      end
    end
    bad_words = 0;
    for (int i = 0; i < 64; i++)
      if (rd(32'h2000 + 32'(i * 4)) !== pat(32'(i * 4))) bad_words++;
    n_chk++;
    if (bad_words != 0) begin n_bad++; $display("FAIL single_data: got %0d bad words want 0", bad_words); end
  endtask

  task automatic test_short();
    int unsigned bad_words;
    clear_logs();
    apb_wr(12'h400, 32'h0000_0300);
    apb_wr(12'h404, 32'h0000_3300);
    apb_wr(12'h408, 32'h0000_0014);
    apb_wr(12'h40C, 32'd1);
    wait_idle(3);
    n_chk++;
    if (ar_log.size() != 1 || aw_log.size() != 1 || ar_log[0] !== {4'd4, 32'h300} ||
        aw_log[0] !== {4'd4, 32'h3300}) begin
      n_bad++; $display("FAIL short_burst: got ar_n=%0d aw_n=%0d want one ar=4/300 aw=4/3300",
                        ar_log.size(), aw_log.size());
    end
    n_chk++;
    if (wbeats != 5 || wlast_cnt != 1) begin
      n_bad++; $display("FAIL short_beats: got wbeats=%0d wlast=%0d want 5 1", wbeats, wlast_cnt);
    end
    bad_words = 0;
    for (int i = 0; i < 5; i++)
      if (rd(32'h3300 + 32'(i * 4)) !== pat(32'h300 + 32'(i * 4))) bad_words++;
    n_chk++;
    if (bad_words != 0 || mem.exists(32'h3314)) begin
      n_bad++; $display("FAIL short_data: got %0d bad words (overrun=%b) want 0", bad_words, mem.exists(32'h3314));
    end
  endtask

  task automatic test_zero_len();
    logic [31:0] d;
    logic        e;
    clear_logs();
    apb_wr(12'h308, 32'd0);
    apb_wr(12'h30C, 32'd1);
    apb_rd(12'h310, d, e);
    n_chk++;
    if (d !== 32'd1) begin n_bad++; $display("FAIL zero_stat: got %h want 1", d); end
    apb_wr(12'h308, 32'd3);
    apb_wr(12'h30C, 32'd1);
    apb_rd(12'h310, d, e);
    n_chk++;
    if (d !== 32'd1) begin n_bad++; $display("FAIL len3_stat: got %h want 1", d); end
    repeat (20) @(negedge clk);
    n_chk++;
    if (ar_log.size() != 0 || aw_log.size() != 0) begin
      n_bad++; $display("FAIL zero_traffic: got ar=%0d aw=%0d want 0 0", ar_log.size(), aw_log.size());
    end
  endtask

  task automatic test_round_robin();
    int unsigned bad_words;
    clear_logs();
    for (int n = 0; n < 4; n++) begin
      apb_wr(12'((n + 1) * 256 + 0), 32'h0001_0000 + 32'(n * 32'h1000));
      apb_wr(12'((n + 1) * 256 + 4), 32'h0002_0000 + 32'(n * 32'h1000));
      apb_wr(12'((n + 1) * 256 + 8), 32'h0000_0100);
    end
    for (int n = 0; n < 4; n++) apb_wr(12'((n + 1) * 256 + 12), 32'd1);
    for (int n = 0; n < 4; n++) wait_idle(n);
    n_chk++;
    if (ar_log.size() != 16 || aw_log.size() != 16) begin
      n_bad++; $display("FAIL rr_bursts: got ar=%0d aw=%0d want 16 16", ar_log.size(), aw_log.size());
    end else begin
      for (int k = 0; k < 4; k++)
        for (int n = 0; n < 4; n++) begin
          n_chk++;
          if (ar_log[k * 4 + n] !== {4'd15, 32'h0001_0000 + 32'(n * 32'h1000 + k * 64)} ||
              aw_log[k * 4 + n] !== {4'd15, 32'h0002_0000 + 32'(n * 32'h1000 + k * 64)}) begin
            n_bad++;
            $display("FAIL rr_order%0d: got ar=%h aw=%h want ch%0d burst%0d", k * 4 + n,
                     ar_log[k * 4 + n], aw_log[k * 4 + n], n, k);
          end
        end
    end
    bad_words = 0;
    for (int n = 0; n < 4; n++)
      for (int i = 0; i < 64; i++)
        if (rd(32'h0002_0000 + 32'(n * 32'h1000 + i * 4)) !== pat(32'h0001_0000 + 32'(n * 32'h1000 + i * 4)))
          bad_words++;
    n_chk++;
    if (bad_words != 0) begin n_bad++; $display("FAIL rr_data: got %0d bad words want 0", bad_words); end
  endtask

  task automatic test_stalls_busy();
    logic [31:0] d;
    logic        e;
    int unsigned bad_words;
    clear_logs();
    stall_en = 1'b1;
    apb_wr(12'h200, 32'h0000_4000);
    apb_wr(12'h204, 32'h0000_6000);
    apb_wr(12'h208, 32'h0000_0080);
    apb_wr(12'h20C, 32'd1);
    apb_wr(12'h200, 32'h0000_9000);
    apb_wr(12'h208, 32'h0000_0040);
    apb_wr(12'h20C, 32'd1);
    wait_idle(1);
    stall_en = 1'b0;
    n_chk++;
    if (ar_log.size() != 2 || ar_log[0] !== {4'd15, 32'h4000} || ar_log[1] !== {4'd15, 32'h4040}) begin
      n_bad++; $display("FAIL stall_shadow: got %0d ar bursts first=%h want 2 from 4000", ar_log.size(), ar_log[0]);
    end
    bad_words = 0;
    for (int i = 0; i < 32; i++)
      if (rd(32'h6000 + 32'(i * 4)) !== pat(32'h4000 + 32'(i * 4))) bad_words++;
    n_chk++;
    if (bad_words != 0) begin n_bad++; $display("FAIL stall_data: got %0d bad words want 0", bad_words); end
    apb_rd(12'h200, d, e);
    n_chk++;
    if (d !== 32'h0000_9000) begin n_bad++; $display("FAIL shadow_src: got %h want 00009000", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic        e;
    logic        exp_err;
    bit          seen;
`ifdef DMAC_SLVERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    clear_logs();
    apb_wr(12'h300, 32'h0000_5000);
    apb_wr(12'h304, 32'h0000_7000);
    apb_wr(12'h308, 32'h0000_0100);
    apb_wr(12'h30C, 32'd1);
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (rbeats >= 3 && rready_o) seen = 1;
    end
    n_chk++;
    if (!seen) begin n_bad++; $display("FAIL mid_rdata_timeout: got %0d beats want >=3", rbeats); end
    @(posedge clk);
    #3 rst = 1;
    #1;
    n_chk++;
    if ({arvalid_o, rready_o, awvalid_o, wvalid_o, wlast_o, bready_o} !== 6'b0) begin
      n_bad++; $display("FAIL rst_valids: got %b want 000000",
                        {arvalid_o, rready_o, awvalid_o, wvalid_o, wlast_o, bready_o});
    end
    repeat (2) @(negedge clk);
    rst = 0;
    for (int n = 0; n < 4; n++) begin
      apb_rd(12'((n + 1) * 256 + 16), d, e);
      n_chk++;
      if (d !== 32'd1) begin n_bad++; $display("FAIL rst_stat ch%0d: got %h want 1", n, d); end
    end
    apb_rd(12'h500, d, e);
    n_chk++;
    if (e !== exp_err) begin n_bad++; $display("FAIL rst_slverr: got %b want %b", e, exp_err); end
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", n_chk, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_regs();
    test_single_ch();
    test_short();
    test_zero_len();
    test_round_robin();
    test_stalls_busy();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
